// File: rtl/approx_accum.sv
// Streaming accumulator on a lower-part-OR approximate adder with valid/ready framing.
// Define APPROX_ACCUM_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module approx_accum #(
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 16,
  parameter int APPROX_BITS = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]        out_count,
  output logic                        out_ovf
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam int HI_W = ACC_WIDTH - APPROX_BITS;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;
  logic                   out_ovf_q, out_ovf_d;
  logic                   out_valid_q, out_valid_d;

  logic [ACC_WIDTH-1:0]   in_ext;
  logic [ACC_WIDTH-1:0]   raw_sum;
  logic [ACC_WIDTH-1:0]   sum_next;
  logic                   add_ovf;
  logic [CNT_WIDTH-1:0]   count_inc;

  generate
    if (ACC_WIDTH > WIDTH) begin : g_sext
      assign in_ext = {{(ACC_WIDTH-WIDTH){in_data[WIDTH-1]}}, in_data};
    end else begin : g_nosext
      assign in_ext = in_data;
    end
  endgenerate

  // Lower K bits are ORed; the only carry into the exact upper part is A[K-1]&B[K-1].
  generate
    if (APPROX_BITS == 0) begin : g_exact
      assign raw_sum = acc_q + in_ext;
    end else begin : g_approx
      logic [APPROX_BITS-1:0] lo;
      logic [HI_W-1:0]        hi;
      logic                   carry;
      assign lo      = acc_q[APPROX_BITS-1:0] | in_ext[APPROX_BITS-1:0];
      assign carry   = acc_q[APPROX_BITS-1] & in_ext[APPROX_BITS-1];
      assign hi      = acc_q[ACC_WIDTH-1:APPROX_BITS] + in_ext[ACC_WIDTH-1:APPROX_BITS]
                     + HI_W'(carry);
      assign raw_sum = {hi, lo};
    end
  endgenerate

  assign add_ovf = (acc_q[ACC_WIDTH-1] == in_ext[ACC_WIDTH-1]) &&
                   (raw_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

`ifdef APPROX_ACCUM_SAT_EN
  localparam logic [ACC_WIDTH-1:0] MAX_POS = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MAX_NEG = ~MAX_POS;
  assign sum_next = add_ovf ? (acc_q[ACC_WIDTH-1] ? MAX_NEG : MAX_POS) : raw_sum;
`else
  assign sum_next = raw_sum;
`endif

  assign count_inc = (count_q == '1) ? count_q : count_q + CNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        // clear discards a coincident sample, including its in_last
        if (clear) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (in_valid) begin
          if (in_last) begin
            out_data_d  = sum_next;
            out_count_d = count_inc;
            out_ovf_d   = ovf_q | add_ovf;
            out_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d   = sum_next;
            count_d = count_inc;
            ovf_d   = ovf_q | add_ovf;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_approx_accum.sv
// Directed bench for approx_accum: four instances with different adder/counter
// parameters share one stimulus stream and are checked against hand-computed values.
module tb_approx_accum;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       inValid = 1'b0;
   logic [7:0] inData = 8'd0;
   logic       inLast = 1'b0;
   logic       outReady = 1'b0;

   logic        exReady, exValid, exOvf;
   logic [15:0] exData;
   logic [7:0]  exCount;

   logic        apReady, apValid, apOvf;
   logic [11:0] apData;
   logic [7:0]  apCount;

   logic        ovReady, ovValid, ovOvf;
   logic [11:0] ovData;
   logic [7:0]  ovCount;

   logic        ctReady, ctValid, ctOvf;
   logic [15:0] ctData;
   logic [2:0]  ctCount;

   int checks = 0;
   int failures = 0;
   logic [31:0] heldData;

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   approx_accum #(.WIDTH(8), .ACC_WIDTH(16), .APPROX_BITS(0), .CNT_WIDTH(8)) uExact (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(inValid), .in_ready(exReady),
      .in_data(inData), .in_last(inLast), .out_valid(exValid), .out_ready(outReady),
      .out_data(exData), .out_count(exCount), .out_ovf(exOvf));

   approx_accum #(.WIDTH(8), .ACC_WIDTH(12), .APPROX_BITS(2), .CNT_WIDTH(8)) uApx (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(inValid), .in_ready(apReady),
      .in_data(inData), .in_last(inLast), .out_valid(apValid), .out_ready(outReady),
      .out_data(apData), .out_count(apCount), .out_ovf(apOvf));

   approx_accum #(.WIDTH(8), .ACC_WIDTH(12), .APPROX_BITS(0), .CNT_WIDTH(8)) uOvf (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(inValid), .in_ready(ovReady),
      .in_data(inData), .in_last(inLast), .out_valid(ovValid), .out_ready(outReady),
      .out_data(ovData), .out_count(ovCount), .out_ovf(ovOvf));

   approx_accum #(.WIDTH(8), .ACC_WIDTH(16), .APPROX_BITS(4), .CNT_WIDTH(3)) uCnt (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(inValid), .in_ready(ctReady),
      .in_data(inData), .in_last(inLast), .out_valid(ctValid), .out_ready(outReady),
      .out_data(ctData), .out_count(ctCount), .out_ovf(ctOvf));

   // Drive the shared input stream
   task automatic applyStimulus(input logic valid, input logic [7:0] data,
                                input logic last, input logic clr);
      inValid = valid;
      inData  = data;
      inLast  = last;
      clear   = clr;
   endtask

   // Advance to just after the next rising edge
   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   // One counted comparison
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Linear directed sequence
   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      checkOutput("reset_in_ready", 32'(exReady), 32'd1);
      checkOutput("reset_out_valid", 32'(exValid), 32'd0);
      checkOutput("reset_out_data", 32'(exData), 32'd0);
      checkOutput("reset_out_count", 32'(exCount), 32'd0);
      checkOutput("reset_out_ovf", 32'(exOvf), 32'd0);

      // Vector 3, 5, -2
      outReady = 1'b1;
      applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
      stepClk();
      applyStimulus(1'b1, 8'd5, 1'b0, 1'b0);
      stepClk();
      applyStimulus(1'b1, 8'hFE, 1'b1, 1'b0);
      checkOutput("v1_no_early_valid", 32'(exValid), 32'd0);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("v1_valid", 32'(exValid), 32'd1);
      checkOutput("v1_in_ready_low", 32'(exReady), 32'd0);
      checkOutput("v1_exact_data", 32'(exData), 32'd6);
      checkOutput("v1_exact_count", 32'(exCount), 32'd3);
      checkOutput("v1_exact_ovf", 32'(exOvf), 32'd0);
      checkOutput("v1_apx2_data", 32'(apData), 32'd7);
      checkOutput("v1_w12_data", 32'(ovData), 32'd6);
      checkOutput("v1_apx4_data", 32'(ctData), 32'h0000FFFF);
      checkOutput("v1_cnt3_count", 32'(ctCount), 32'd3);
      stepClk();
      checkOutput("v1_release_valid", 32'(exValid), 32'd0);
      checkOutput("v1_release_ready", 32'(exReady), 32'd1);

      // Vector 3, 3 with backpressure
      outReady = 1'b0;
      applyStimulus(1'b1, 8'd3, 1'b0, 1'b0);
      stepClk();
      applyStimulus(1'b1, 8'd3, 1'b1, 1'b0);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("v2_apx2_data", 32'(apData), 32'd7);
      checkOutput("v2_exact_data", 32'(exData), 32'd6);
      for (int i = 0; i < 5; i++) begin
         stepClk();
         checkOutput("bp_valid", 32'(apValid), 32'd1);
         checkOutput("bp_in_ready", 32'(apReady), 32'd0);
         checkOutput("bp_data_stable", 32'(apData), 32'd7);
      end
      outReady = 1'b1;
      stepClk();
      checkOutput("bp_release_valid", 32'(apValid), 32'd0);
      checkOutput("bp_release_ready", 32'(apReady), 32'd1);

      // Overflow: 127 x20; 12-bit wraps to -1556 (0x9EC) or saturates at 2047
      outReady = 1'b0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 8'd127, (i == 19), 1'b0);
         stepClk();
      end
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
`ifdef APPROX_ACCUM_SAT_EN
      checkOutput("ovf_data", 32'(ovData), 32'h000007FF);
`else
      checkOutput("ovf_data", 32'(ovData), 32'h000009EC);
`endif
      checkOutput("ovf_flag", 32'(ovOvf), 32'd1);
      checkOutput("ovf_count", 32'(ovCount), 32'd20);
      checkOutput("ovf_wide_data", 32'(exData), 32'd2540);
      checkOutput("ovf_wide_flag", 32'(exOvf), 32'd0);
      checkOutput("cnt_saturate", 32'(ctCount), 32'd7);
      outReady = 1'b1;
      stepClk();

      // Clear with a coincident last-flagged sample, then 4(last)
      applyStimulus(1'b1, 8'd10, 1'b0, 1'b0);
      stepClk();
      applyStimulus(1'b1, 8'd20, 1'b0, 1'b0);
      stepClk();
      applyStimulus(1'b1, 8'd7, 1'b1, 1'b1);
      checkOutput("clr_handshake", 32'(exReady), 32'd1);
      stepClk();
      checkOutput("clr_last_dropped", 32'(exValid), 32'd0);
      applyStimulus(1'b1, 8'd4, 1'b1, 1'b0);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("clr_exact_data", 32'(exData), 32'd4);
      checkOutput("clr_exact_count", 32'(exCount), 32'd1);
      checkOutput("clr_apx2_data", 32'(apData), 32'd4);
      checkOutput("clr_w12_ovf_reset", 32'(ovOvf), 32'd0);
      stepClk();

      // Reset mid-vector
      applyStimulus(1'b1, 8'd5, 1'b0, 1'b0);
      stepClk();
      applyStimulus(1'b1, 8'd6, 1'b0, 1'b0);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_async_data", 32'(exData), 32'd0);
      checkOutput("rst_async_count", 32'(exCount), 32'd0);
      checkOutput("rst_async_valid", 32'(exValid), 32'd0);
      stepClk();
      rst = 1'b0;
      outReady = 1'b0;
      applyStimulus(1'b1, 8'd9, 1'b1, 1'b0);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("rst_next_data", 32'(exData), 32'd9);
      checkOutput("rst_next_count", 32'(exCount), 32'd1);
      checkOutput("rst_next_apx2", 32'(apData), 32'd9);

      // clear while holding a result is ignored
      heldData = 32'(exData);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("hold_clear_data", 32'(exData), 32'd9);
      checkOutput("hold_clear_valid", 32'(exValid), 32'd1);
      outReady = 1'b1;
      stepClk();

      // Back-to-back single-sample vectors
      applyStimulus(1'b1, 8'd1, 1'b1, 1'b0);
      stepClk();
      applyStimulus(1'b1, 8'd2, 1'b1, 1'b0);
      checkOutput("b2b_first_data", 32'(exData), 32'd1);
      checkOutput("b2b_first_count", 32'(exCount), 32'd1);
      checkOutput("b2b_first_ready", 32'(exReady), 32'd0);
      stepClk();
      checkOutput("b2b_bubble_valid", 32'(exValid), 32'd0);
      checkOutput("b2b_bubble_ready", 32'(exReady), 32'd1);
      checkOutput("b2b_bubble_data", 32'(exData), 32'd1);
      stepClk();
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("b2b_second_valid", 32'(exValid), 32'd1);
      checkOutput("b2b_second_data", 32'(exData), 32'd2);
      checkOutput("b2b_second_count", 32'(exCount), 32'd1);
      stepClk();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/approx_accum.md
Name: approx_accum

Overview:
- Parametrised streaming accumulator built on a lower-part-OR approximate adder, for CNN dot-product / MAC reduction.
- Generalises the single-bit full adder cell to a WIDTH-in, ACC_WIDTH-wide adder with a configurable number of approximate LSBs.
- Adds valid/ready handshaking, per-vector framing, overflow reporting and result buffering.
- Sits after the approximate multiplier array and feeds the activation stage.

Parameters:
- WIDTH, 8, signed input sample width.
- ACC_WIDTH, 16, signed accumulator width; must be ≥ WIDTH.
- APPROX_BITS, 4, number of LSBs computed approximately; range 0..ACC_WIDTH-1; 0 gives an exact adder.
- CNT_WIDTH, 8, sample counter width.

Ports:
- clk, in, 1, clock; all logic is rising-edge.
- rst, in, 1, asynchronous active-high reset.
- clear, in, 1, synchronous discard of the partial sum.
- in_valid, in, 1, input sample valid.
- in_ready, out, 1, accumulator can accept a sample.
- in_data, in, WIDTH, signed sample.
- in_last, in, 1, marks the final sample of a vector.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- out_data, out, ACC_WIDTH, signed vector sum.
- out_count, out, CNT_WIDTH, number of samples in the vector; saturates at all-ones.
- out_ovf, out, 1, overflow occurred within the vector.

Behaviour:
- Reset: state=ACC; acc, count, ovf, out_data, out_count and out_ovf are 0; out_valid=0; in_ready=1 on the first cycle after reset deasserts.
- Reset asserted mid-vector or during HOLD clears everything immediately and drops any pending result.
- Approximate add, sum = add(A, B), with K=APPROX_BITS:
  - Bits [K-1:0]: sum[i] = A[i] | B[i].
  - Carry into bit K is A[K-1] & B[K-1].
  - Bits [ACC_WIDTH-1:K]: exact ripple add of the upper parts plus that carry.
  - K=0 is an exact add with carry-in 0.
- in_data is sign-extended to ACC_WIDTH before the add.
- Overflow: the operands have the same sign and sum[ACC_WIDTH-1] differs from it. Handling of the stored value is defined under Optional Feature.
- FSM, two states:
  - ACC: in_ready=1. On a transfer (in_valid&in_ready): acc <= add(acc, sext(in_data)), count <= count+1 (saturating), ovf <= ovf | overflow.
    - If in_last is also set, the new sum, count and ovf load into the out_* registers; acc, count and ovf reset to 0; state goes to HOLD. out_valid rises on the next edge, giving 1-cycle latency from the last sample.
  - HOLD: in_ready=0, and out_data, out_count and out_ovf are stable. On out_valid&out_ready: out_valid <= 0, state goes to ACC, and in_ready=1 in the following cycle.
- Throughput: 1 sample/clk inside a vector. There is a minimum 1-cycle input bubble per vector.
- clear in ACC: acc, count and ovf go to 0. clear wins over a simultaneous transfer; that sample is still handshaken (in_ready=1) but discarded, including its in_last.
- clear in HOLD is ignored; the buffered result is unaffected.
- A single-sample vector (in_last on the first sample) is legal.
- count wraps never: it saturates at 2^CNT_WIDTH-1.
- The output registers change only on a last-transfer or on reset.

Optional Feature:
- Macro: APPROX_ACCUM_SAT_EN.
- Defined: on overflow, acc is forced to max positive (operands ≥0) or max negative (operands <0). Accumulation continues from the saturated value.
- Undefined: acc takes the wrapped two's-complement sum.
- out_ovf is reported identically in both builds.

Test Plan:
- Exact path: APPROX_BITS=0; input 3, 5, -2(last) -> out_data=6, out_count=3, out_ovf=0; out_valid high 1 cycle after the last transfer.
- Approximate path: APPROX_BITS=2, ACC_WIDTH=12; input 3 then 3(last) -> out_data=7 (exact result is 6; the lower OR gives 11 and the carry into bit 2 is 1).
- Backpressure: hold out_ready=0 for 5 cycles after the result -> out_valid=1, in_ready=0, out_data stable; raise out_ready -> out_valid=0 next cycle, in_ready=1.
- Overflow: WIDTH=8, ACC_WIDTH=12, APPROX_BITS=0; 127 x20 (last on the 20th) -> with the macro out_data=2047, out_ovf=1; without it out_data=-1556, out_ovf=1; out_count=20 in both.
- Clear and reset: send 10, 20, then clear together with in_valid=1 carrying 7, then 4(last) -> out_data=4, out_count=1. Separately, assert rst mid-vector -> all outputs 0 asynchronously, and the next vector sums from 0.
- Back-to-back vectors with out_ready=1: 1(last), 2(last) -> results 1 and 2, each out_count=1, one bubble cycle between transfers.
